alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 11 +
 rtl/sat_counter.sv | 20 ++
 rtl/alu_result_fifo.sv | 91 +++++++++
 tb/tb_alu_result_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: status bit positions and width.
// Imported by the ALU operation modules and the result FIFO.
package alu_pkg;

  localparam int STATUS_W = 4;
  localparam int ST_ERR   = 0;
  localparam int ST_NEG   = 1;
  localparam int ST_PAR   = 2;
  localparam int ST_ONES  = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc and holds at all-ones.
// Latency: count visible one cycle after i_inc; no backpressure.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != {WIDTH{1'b1}})) begin
      o_cnt <= o_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO between the ALU and its consumer, with error counting and drop flag.
// Latency: one cycle write-to-head, no fall-through; o_ready depends only on occupancy.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int m     = 4,
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [m-1:0]              i_result,
  input  logic [STATUS_W-1:0]       i_status,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [m-1:0]              o_result,
  output logic [STATUS_W-1:0]       o_status,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [7:0]                o_err_cnt,
  output logic                      o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_result_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [m-1:0]        res_mem [DEPTH];
  logic [STATUS_W-1:0] st_mem  [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                wr_en;
  logic                rd_en;

  assign o_ready = (count != FULL);
  assign o_valid = (count != '0);
  assign o_count = count;
  assign wr_en   = i_valid && o_ready;
  assign rd_en   = o_valid && i_ready;

  // Errored results may carry X; store zero instead so nothing undefined leaves the FIFO.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      res_mem[wr_ptr] <= i_status[ST_ERR] ? '0 : i_result;
      st_mem[wr_ptr]  <= i_status;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_drop <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (i_valid && !o_ready) o_drop <= 1'b1;
    end
  end

  // Gate the head so stale storage never appears while empty.
  always_comb begin
    o_result = '0;
    o_status = '0;
    if (o_valid) begin
      o_result = res_mem[rd_ptr];
      o_status = st_mem[rd_ptr];
    end
  end

  sat_counter #(
    .WIDTH(8)
  ) u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (wr_en && i_status[ST_ERR]),
    .o_cnt (o_err_cnt)
  );

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (m=4, DEPTH=4).
module tb_alu_result_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] in_result;
  logic [3:0] in_status;
  logic       out_valid;
  logic       in_ready;
  logic [3:0] out_result;
  logic [3:0] out_status;
  logic [2:0] out_count;
  logic [7:0] err_cnt;
  logic       drop;

  int total = 0;
  int bad   = 0;

  alu_result_fifo #(.m(4), .DEPTH(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (in_valid),
    .o_ready   (out_ready),
    .i_result  (in_result),
    .i_status  (in_status),
    .o_valid   (out_valid),
    .i_ready   (in_ready),
    .o_result  (out_result),
    .o_status  (out_status),
    .o_count   (out_count),
    .o_err_cnt (err_cnt),
    .o_drop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b0; in_result = 4'h0; in_status = 4'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] s);
    in_valid = 1'b1; in_result = r; in_status = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    total++; if (out_result !== 4'h0) begin bad++; $display("FAIL reset_result: got %0h expected 0", out_result); end
    total++; if (out_status !== 4'h0) begin bad++; $display("FAIL reset_status: got %0h expected 0", out_status); end
    total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b expected 1", out_ready); end
    total++; if (out_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %0b expected 0", drop); end
  endtask

  task automatic test_single_write();
    do_reset();
    push(4'b0011, 4'b0100);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
    total++; if (out_result !== 4'b0011) begin bad++; $display("FAIL single_result: got %0h expected 3", out_result); end
    total++; if (out_status !== 4'b0100) begin bad++; $display("FAIL single_status: got %0h expected 4", out_status); end
    total++; if (out_count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d expected 1", out_count); end
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid: got %0b expected 0", out_valid); end
    total++; if (out_result !== 4'h0) begin bad++; $display("FAIL single_drain_result: got %0h expected 0", out_result); end
  endtask

  task automatic test_sanitize();
    do_reset();
    push(4'hf, 4'b1011);
    total++; if (out_result !== 4'h0) begin bad++; $display("FAIL sanitize_result: got %0h expected 0", out_result); end
    total++; if (out_status !== 4'b1011) begin bad++; $display("FAIL sanitize_status: got %0h expected b", out_status); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL sanitize_errcnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_fill_drop();
    do_reset();
    for (int k = 1; k <= 4; k++) push(4'(k), 4'h0);
    total++; if (out_count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d expected 4", out_count); end
    total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL fill_ready: got %0b expected 0", out_ready); end
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL fill_drop_early: got %0b expected 0", drop); end
    push(4'h5, 4'b0001);
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL fill_drop: got %0b expected 1", drop); end
    total++; if (out_count !== 3'd4) begin bad++; $display("FAIL fill_count_after_drop: got %0d expected 4", out_count); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL fill_errcnt_dropped: got %0d expected 0", err_cnt); end
    in_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (out_result !== 4'(k)) begin bad++; $display("FAIL fill_drain_order: got %0h expected %0h", out_result, k); end
      step();
    end
    in_ready = 1'b0;
    total++; if (out_count !== 3'd0) begin bad++; $display("FAIL fill_drain_count: got %0d expected 0", out_count); end
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL fill_drop_sticky: got %0b expected 1", drop); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(4'h1, 4'h0);
    push(4'h2, 4'h0);
    in_valid = 1'b1; in_ready = 1'b1; in_status = 4'h0;
    for (int c = 0; c < 6; c++) begin
      in_result = 4'(3 + c);
      total++; if (out_result !== 4'(c + 1)) begin bad++; $display("FAIL b2b_order: got %0h expected %0h", out_result, c + 1); end
      step();
      total++; if (out_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", out_count); end
    end
    in_valid = 1'b0;
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL b2b_drop: got %0b expected 0", drop); end
    for (int k = 7; k <= 8; k++) begin
      total++; if (out_result !== 4'(k)) begin bad++; $display("FAIL b2b_tail: got %0h expected %0h", out_result, k); end
      step();
    end
    in_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int k = 9; k <= 12; k++) push(4'(k), 4'h0);
    in_valid = 1'b1; in_ready = 1'b1; in_result = 4'd13;
    step();
    in_valid = 1'b0;
    total++; if (out_count !== 3'd3) begin bad++; $display("FAIL fullrw_count: got %0d expected 3", out_count); end
    total++; if (drop !== 1'b1) begin bad++; $display("FAIL fullrw_drop: got %0b expected 1", drop); end
    for (int k = 10; k <= 12; k++) begin
      total++; if (out_result !== 4'(k)) begin bad++; $display("FAIL fullrw_order: got %0h expected %0h", out_result, k); end
      step();
    end
    in_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullrw_no_write: got %0b expected 0", out_valid); end
  endtask

  task automatic test_err_saturate();
    do_reset();
    in_valid = 1'b1; in_ready = 1'b1; in_status = 4'b0001; in_result = 4'bxxxx;
    for (int c = 1; c <= 300; c++) begin
      step();
      total++; if (out_result !== 4'h0) begin bad++; $display("FAIL sat_result: got %0h expected 0 at word %0d", out_result, c); end
      if (c == 10) begin
        total++; if (err_cnt !== 8'd10) begin bad++; $display("FAIL sat_errcnt_mid: got %0d expected 10", err_cnt); end
      end
    end
    in_valid = 1'b0;
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_errcnt: got %0d expected 255", err_cnt); end
    step();
    in_ready = 1'b0;
    total++; if (out_count !== 3'd0) begin bad++; $display("FAIL sat_drained: got %0d expected 0", out_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 4; k++) push(4'(k), 4'b0001);
    push(4'h5, 4'h0);
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    total++; if (out_count !== 3'd3) begin bad++; $display("FAIL rstmid_pre_count: got %0d expected 3", out_count); end
    rst = 1'b1; in_valid = 1'b1; in_result = 4'h6; in_status = 4'h0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_count !== 3'd0) begin bad++; $display("FAIL rstmid_count: got %0d expected 0", out_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b expected 0", out_valid); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_errcnt: got %0d expected 0", err_cnt); end
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL rstmid_drop: got %0b expected 0", drop); end
    total++; if (out_result !== 4'h0) begin bad++; $display("FAIL rstmid_result: got %0h expected 0", out_result); end
    step();
    total++; if (out_count !== 3'd0) begin bad++; $display("FAIL rstmid_word_lost: got %0d expected 0", out_count); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b0; in_result = 4'h0; in_status = 4'h0;
    #1;
    test_reset();
    test_single_write();
    test_sanitize();
    test_fill_drop();
    test_back_to_back();
    test_full_rw();
    test_err_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
